axis_bram_frame_writer: RTL and testbench
=========================================

// Module: axis_bram_frame_writer
// PURPOSE
//  AXI4-Stream slave that captures one frame (tlast-delimited) into a single-port BRAM.
//  Successor to the fixed-function stream-to-BRAM writer: parametrised depth/width,
//  registered BRAM port, null-beat handling, overflow policy and a frame-done/re-arm handshake.
//  Sits between a DMA/stream source and a BRAM later read by the compute core.
// PARAMETERS
//  DATA_WIDTH  32  tdata/BRAM data width; multiple of 8.
//  DEPTH       11  BRAM words per frame buffer; >= 1.
//  WRAP_EN     0   0: beats beyond DEPTH are drained and dropped. 1: pointer wraps to 0.
//  ADDR_WIDTH  (localparam) max(1, $clog2(DEPTH)).
// PORTS
//  aclk        in   1              clock; all logic on rising edge.
//  areset      in   1              asynchronous reset, active-high.
//  s_tvalid    in   1              stream beat valid.
//  s_tready    out  1              slave ready.
//  s_tdata     in   DATA_WIDTH     stream data.
//  s_tkeep     in   DATA_WIDTH/8   byte qualifiers -> BRAM byte write enables.
//  s_tlast     in   1              last beat of frame.
//  arm         in   1              single-cycle pulse: release DONE, start next capture.
//  frame_done  out  1              high while a captured frame awaits arm.
//  frame_len   out  ADDR_WIDTH+1   words written in current/last frame, saturates at DEPTH.
//  overflow    out  1              sticky: frame exceeded DEPTH (dropped or wrapped).
//  bram_en     out  1              BRAM enable.
//  bram_we     out  DATA_WIDTH/8   BRAM byte write enables.
//  bram_addr   out  ADDR_WIDTH     BRAM word address.
//  bram_din    out  DATA_WIDTH     BRAM write data.
// BEHAVIOUR
//  - Reset (async assert): state IDLE; s_tready, frame_done, frame_len, overflow, bram_* all 0;
//    a write strobe in flight is killed. s_tready rises the first clock after deassertion.
//  - States: IDLE (no beat yet) -> WRITE on first accepted beat without tlast;
//    IDLE/WRITE -> DONE on accepted beat with tlast; DONE -> IDLE on arm. arm elsewhere ignored.
//  - s_tready = registered (state != DONE); low exactly in DONE. Beat accepted = tvalid & tready.
//  - Accepted beat with tkeep != 0 and ptr in range: one BRAM write issued the next cycle
//    (latency 1): bram_en=1, bram_we=tkeep, bram_addr=ptr, bram_din=tdata; ptr++, frame_len++.
//  - Cycles with no write: bram_en=0, bram_we=0, bram_addr=0, bram_din=0.
//  - Null beat (tkeep == 0): accepted, no write, no ptr/len change; its tlast still ends frame.
//  - ptr reaches DEPTH: WRAP_EN=0 -> later beats accepted and dropped (no write), overflow=1;
//    WRAP_EN=1 -> ptr wraps to 0, writes continue, overflow=1. frame_len saturates at DEPTH.
//  - frame_done = 1 from the cycle after the tlast handshake until the cycle after arm.
//  - arm clears ptr, frame_len, overflow in the same edge that returns state to IDLE.
//  - tlast write and frame_done rise on the same cycle; BRAM content is final when frame_done=1.
//  - DEPTH=1: every non-null beat targets address 0; second non-null beat sets overflow.
// STRUCTURE
//  - Package axis_bram_pkg: state enum {IDLE, WRITE, DONE}, addr-width function, WRAP/DROP consts.
//  - Sub-module axis_bram_wr_ptr: pointer, saturating length counter, wrap/overflow logic.
//  - Top: FSM, ready generation, registered BRAM write stage.
// TESTING
//  1. 4-beat frame, tkeep=F, data 0xA0..0xA3, tlast on beat 3 -> writes addr 0..3 one cycle
//     after each handshake; frame_done=1, frame_len=4, s_tready=0 until arm.
//  2. tvalid toggling every other cycle, 3 beats -> exactly 3 writes, addresses contiguous.
//  3. WRAP_EN=0, DEPTH=11, 14-beat frame -> writes addr 0..10, beats 11..13 accepted
//     without writes, frame_len=11, overflow=1.
//  4. WRAP_EN=1, DEPTH=11, 13-beat frame -> beats 11,12 written to addr 0,1; overflow=1.
//  5. Frame with beat 1 tkeep=0 and tkeep=0x3 on beat 2 -> beat 1 not written, beat 2
//     written at addr 1 with bram_we=0x3; frame_len=2.
//  6. areset asserted mid-frame after 2 beats -> outputs 0 immediately; after release a
//     new frame writes from addr 0, overflow=0, frame_len restarts at 0.

Source files
------------

// File: rtl/axis_bram_pkg.sv
// Shared types and constants for the AXI4-Stream to BRAM frame writer.
package axis_bram_pkg;

  typedef enum logic [1:0] {
    IDLE,
    WRITE,
    DONE
  } state_t;

  localparam bit WRAP = 1'b1;
  localparam bit DROP = 1'b0;

  // A single-word buffer still needs a 1-bit address port.
  function automatic int unsigned addr_width(input int unsigned depth);
    return (depth <= 2) ? 1 : $clog2(depth);
  endfunction

endpackage

// File: rtl/axis_bram_frame_writer_if.sv
// AXI4-Stream beat channel between a stream source and the frame writer.
interface axis_bram_frame_writer_if #(
  parameter int unsigned DATA_WIDTH = 32
);

  logic                    tvalid;
  logic                    tready;
  logic [DATA_WIDTH-1:0]   tdata;
  logic [DATA_WIDTH/8-1:0] tkeep;
  logic                    tlast;

  modport master (output tvalid, tdata, tkeep, tlast, input tready);
  modport slave  (input tvalid, tdata, tkeep, tlast, output tready);

endinterface

// File: rtl/axis_bram_wr_ptr.sv
// Write pointer, saturating frame length and sticky overflow for one frame buffer.
module axis_bram_wr_ptr
  import axis_bram_pkg::*;
#(
  parameter int unsigned DEPTH      = 11,
  parameter bit          WRAP_EN    = DROP,
  parameter int unsigned ADDR_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_beat,
  input  logic                  i_clr,
  output logic [ADDR_WIDTH-1:0] o_ptr,
  output logic                  o_wr_ok,
  output logic [ADDR_WIDTH:0]   o_len,
  output logic                  o_ovf
);

  localparam logic [ADDR_WIDTH-1:0] LAST_PTR = ADDR_WIDTH'(DEPTH - 1);
  localparam logic [ADDR_WIDTH:0]   LEN_MAX  = (ADDR_WIDTH + 1)'(DEPTH);

  logic [ADDR_WIDTH-1:0] r_ptr;
  logic [ADDR_WIDTH:0]   r_len;
  logic                  r_ovf;
  logic                  w_full;

  // Without wrap the length doubles as the "pointer ran past the end" flag.
  assign w_full  = (r_len == LEN_MAX);
  assign o_wr_ok = (WRAP_EN == WRAP) || !w_full;
  assign o_ptr   = r_ptr;
  assign o_len   = r_len;
  assign o_ovf   = r_ovf;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ptr <= '0;
      r_len <= '0;
      r_ovf <= 1'b0;
    end else if (i_clr) begin
      r_ptr <= '0;
      r_len <= '0;
      r_ovf <= 1'b0;
    end else if (i_beat) begin
      if (!w_full) begin
        r_len <= r_len + (ADDR_WIDTH + 1)'(1);
      end else begin
        r_ovf <= 1'b1;
      end
      if (o_wr_ok) begin
        r_ptr <= (r_ptr == LAST_PTR) ? '0 : r_ptr + ADDR_WIDTH'(1);
      end
    end
  end

endmodule

// File: rtl/axis_bram_frame_writer.sv
// Captures one tlast-delimited AXI4-Stream frame into a single-port BRAM, then holds until armed.
module axis_bram_frame_writer
  import axis_bram_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned DEPTH      = 11,
  parameter bit          WRAP_EN    = DROP
) (
  input  logic                                aclk,
  input  logic                                areset,
  axis_bram_frame_writer_if.slave             s,
  input  logic                                arm,
  output logic                                frame_done,
  output logic [addr_width(DEPTH):0]          frame_len,
  output logic                                overflow,
  output logic                                bram_en,
  output logic [DATA_WIDTH/8-1:0]             bram_we,
  output logic [addr_width(DEPTH)-1:0]        bram_addr,
  output logic [DATA_WIDTH-1:0]               bram_din
);

  localparam int unsigned ADDR_WIDTH = addr_width(DEPTH);
  localparam int unsigned KEEP_WIDTH = DATA_WIDTH / 8;

  state_t                  r_state;
  logic                    r_tready;
  logic                    r_done;
  logic                    r_en;
  logic [KEEP_WIDTH-1:0]   r_we;
  logic [ADDR_WIDTH-1:0]   r_addr;
  logic [DATA_WIDTH-1:0]   r_din;

  logic                    w_accept;
  logic                    w_beat;
  logic                    w_clr;
  logic                    w_wr_ok;
  logic [ADDR_WIDTH-1:0]   w_ptr;
  logic [ADDR_WIDTH:0]     w_len;
  logic                    w_ovf;

  assign w_accept = s.tvalid & r_tready;
  assign w_beat   = w_accept & (s.tkeep != '0);
  assign w_clr    = arm & (r_state == DONE);

  axis_bram_wr_ptr #(
    .DEPTH      (DEPTH),
    .WRAP_EN    (WRAP_EN),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_wr_ptr (
    .clk     (aclk),
    .rst     (areset),
    .i_beat  (w_beat),
    .i_clr   (w_clr),
    .o_ptr   (w_ptr),
    .o_wr_ok (w_wr_ok),
    .o_len   (w_len),
    .o_ovf   (w_ovf)
  );

  // tready is registered alongside the state so it drops on the same edge DONE is entered.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      r_state  <= IDLE;
      r_tready <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      case (r_state)
        IDLE, WRITE: begin
          r_tready <= 1'b1;
          if (w_accept) begin
            if (s.tlast) begin
              r_state  <= DONE;
              r_tready <= 1'b0;
              r_done   <= 1'b1;
            end else begin
              r_state <= WRITE;
            end
          end
        end
        DONE: begin
          if (arm) begin
            r_state  <= IDLE;
            r_tready <= 1'b1;
            r_done   <= 1'b0;
          end
        end
        default: begin
          r_state  <= IDLE;
          r_tready <= 1'b0;
          r_done   <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      r_en   <= 1'b0;
      r_we   <= '0;
      r_addr <= '0;
      r_din  <= '0;
    end else if (w_beat && w_wr_ok) begin
      r_en   <= 1'b1;
      r_we   <= s.tkeep;
      r_addr <= w_ptr;
      r_din  <= s.tdata;
    end else begin
      r_en   <= 1'b0;
      r_we   <= '0;
      r_addr <= '0;
      r_din  <= '0;
    end
  end

  assign s.tready   = r_tready;
  assign frame_done = r_done;
  assign frame_len  = w_len;
  assign overflow   = w_ovf;
  assign bram_en    = r_en;
  assign bram_we    = r_we;
  assign bram_addr  = r_addr;
  assign bram_din   = r_din;

endmodule

// File: tb/tb_axis_bram_frame_writer.sv
// Randomized bench: three writer variants (drop/11, wrap/11, drop/1) against a frame-level model.
module tb_axis_bram_frame_writer;

  logic        clk = 1'b0;
  logic        areset = 1'b1;
  logic        tvalid = 1'b0;
  logic        tlast = 1'b0;
  logic        arm = 1'b0;
  logic [31:0] tdata = '0;
  logic [3:0]  tkeep = '0;

  always #5 clk = ~clk;

  axis_bram_frame_writer_if #(.DATA_WIDTH(32)) ifc0 ();
  axis_bram_frame_writer_if #(.DATA_WIDTH(32)) ifc1 ();
  axis_bram_frame_writer_if #(.DATA_WIDTH(32)) ifc2 ();

  assign ifc0.tvalid = tvalid; assign ifc0.tdata = tdata; assign ifc0.tkeep = tkeep; assign ifc0.tlast = tlast;
  assign ifc1.tvalid = tvalid; assign ifc1.tdata = tdata; assign ifc1.tkeep = tkeep; assign ifc1.tlast = tlast;
  assign ifc2.tvalid = tvalid; assign ifc2.tdata = tdata; assign ifc2.tkeep = tkeep; assign ifc2.tlast = tlast;

  logic        fd0, fd1, fd2, ov0, ov1, ov2, en0, en1, en2;
  logic [3:0]  we0, we1, we2;
  logic [3:0]  ad0, ad1;
  logic [0:0]  ad2;
  logic [4:0]  len0, len1;
  logic [1:0]  len2;
  logic [31:0] din0, din1, din2;

  axis_bram_frame_writer #(.DATA_WIDTH(32), .DEPTH(11), .WRAP_EN(1'b0)) u_drop (
    .aclk(clk), .areset(areset), .s(ifc0), .arm(arm), .frame_done(fd0), .frame_len(len0),
    .overflow(ov0), .bram_en(en0), .bram_we(we0), .bram_addr(ad0), .bram_din(din0));

  axis_bram_frame_writer #(.DATA_WIDTH(32), .DEPTH(11), .WRAP_EN(1'b1)) u_wrap (
    .aclk(clk), .areset(areset), .s(ifc1), .arm(arm), .frame_done(fd1), .frame_len(len1),
    .overflow(ov1), .bram_en(en1), .bram_we(we1), .bram_addr(ad1), .bram_din(din1));

  axis_bram_frame_writer #(.DATA_WIDTH(32), .DEPTH(1), .WRAP_EN(1'b0)) u_one (
    .aclk(clk), .areset(areset), .s(ifc2), .arm(arm), .frame_done(fd2), .frame_len(len2),
    .overflow(ov2), .bram_en(en2), .bram_we(we2), .bram_addr(ad2), .bram_din(din2));

  logic        o_en[3], o_done[3], o_ovf[3], o_rdy[3];
  logic [31:0] o_we[3], o_addr[3], o_din[3], o_len[3];

  assign o_en[0] = en0;  assign o_en[1] = en1;  assign o_en[2] = en2;
  assign o_done[0] = fd0; assign o_done[1] = fd1; assign o_done[2] = fd2;
  assign o_ovf[0] = ov0; assign o_ovf[1] = ov1; assign o_ovf[2] = ov2;
  assign o_rdy[0] = ifc0.tready; assign o_rdy[1] = ifc1.tready; assign o_rdy[2] = ifc2.tready;
  assign o_we[0] = 32'(we0); assign o_we[1] = 32'(we1); assign o_we[2] = 32'(we2);
  assign o_addr[0] = 32'(ad0); assign o_addr[1] = 32'(ad1); assign o_addr[2] = 32'(ad2);
  assign o_din[0] = din0; assign o_din[1] = din1; assign o_din[2] = din2;
  assign o_len[0] = 32'(len0); assign o_len[1] = 32'(len1); assign o_len[2] = 32'(len2);

  int unsigned n_total = 0;
  int unsigned n_bad = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // Frame-level reference: the k-th non-null beat of a frame lands at k (or k mod DEPTH when wrapping).
  int unsigned DEP[3] = '{11, 11, 1};
  bit          WRP[3] = '{1'b0, 1'b1, 1'b0};
  int unsigned m_nn[3];
  bit          m_done[3], m_rdy[3], p_acc[3], p_arm[3];
  logic [31:0] p_data;
  logic [3:0]  p_keep;
  logic        p_last;
  logic        rst_edge = 1'b1;
  bit          e_en;
  logic [31:0] e_we, e_addr, e_din, e_len;

  always @(posedge clk) rst_edge <= areset;

  always @(negedge clk) begin
    if (areset || rst_edge) begin
      for (int d = 0; d < 3; d++) begin
        m_nn[d] = 0; m_done[d] = 0; m_rdy[d] = 0; p_acc[d] = 0; p_arm[d] = 0;
        check($sformatf("d%0d_rst_en", d), 32'(o_en[d]), 0);
        check($sformatf("d%0d_rst_we", d), o_we[d], 0);
        check($sformatf("d%0d_rst_addr", d), o_addr[d], 0);
        check($sformatf("d%0d_rst_din", d), o_din[d], 0);
        check($sformatf("d%0d_rst_done", d), 32'(o_done[d]), 0);
        check($sformatf("d%0d_rst_rdy", d), 32'(o_rdy[d]), 0);
        check($sformatf("d%0d_rst_len", d), o_len[d], 0);
        check($sformatf("d%0d_rst_ovf", d), 32'(o_ovf[d]), 0);
      end
    end else begin
      for (int d = 0; d < 3; d++) begin
        e_en = 0; e_we = 0; e_addr = 0; e_din = 0;
        if (p_arm[d] && m_done[d]) begin
          m_done[d] = 0;
          m_nn[d] = 0;
        end
        if (p_acc[d]) begin
          if (p_keep != 4'h0) begin
            if (m_nn[d] < DEP[d] || WRP[d]) begin
              e_en = 1; e_we = 32'(p_keep); e_addr = m_nn[d] % DEP[d]; e_din = p_data;
            end
            m_nn[d]++;
          end
          if (p_last) m_done[d] = 1;
        end
        m_rdy[d] = !m_done[d];
        e_len = (m_nn[d] < DEP[d]) ? m_nn[d] : DEP[d];
        check($sformatf("d%0d_en", d), 32'(o_en[d]), 32'(e_en));
        check($sformatf("d%0d_we", d), o_we[d], e_we);
        check($sformatf("d%0d_addr", d), o_addr[d], e_addr);
        check($sformatf("d%0d_din", d), o_din[d], e_din);
        check($sformatf("d%0d_done", d), 32'(o_done[d]), 32'(m_done[d]));
        check($sformatf("d%0d_rdy", d), 32'(o_rdy[d]), 32'(m_rdy[d]));
        check($sformatf("d%0d_len", d), o_len[d], e_len);
        check($sformatf("d%0d_ovf", d), 32'(o_ovf[d]), 32'(m_nn[d] > DEP[d]));
        p_acc[d] = tvalid && m_rdy[d];
        p_arm[d] = arm;
      end
      p_data = tdata;
      p_keep = tkeep;
      p_last = tlast;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_beat(input logic [31:0] d, input logic [3:0] k, input logic l, input bit gap);
    int unsigned waitc;
    bit acc;
    if (gap) begin
      tvalid = 1'b0;
      tick();
    end
    tvalid = 1'b1; tdata = d; tkeep = k; tlast = l;
    waitc = 0;
    acc = 0;
    while (!acc && waitc < 40) begin
      acc = o_rdy[0];
      tick();
      waitc++;
    end
    if (!acc) check("beat_timeout", 32'(acc), 1);
    tvalid = 1'b0;
    tlast = 1'b0;
  endtask

  task automatic pulse_arm();
    arm = 1'b1;
    tick();
    arm = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int unsigned flen, junk;
    logic [3:0] k;
    areset = 1'b1;
    repeat (3) tick();
    areset = 1'b0;
    tick();
    tick();

    for (int i = 0; i < 4; i++) send_beat(32'hA0 + 32'(i), 4'hF, i == 3, 1'b0);
    check("t1_done", 32'(o_done[0]), 1);
    check("t1_len", o_len[0], 4);
    check("t1_rdy", 32'(o_rdy[0]), 0);
    tick();
    tick();
    check("t1_hold", 32'(o_done[0]), 1);
    pulse_arm();
    check("t1_rearm", 32'(o_done[0]), 0);
    check("t1_len_clr", o_len[0], 0);

    for (int i = 0; i < 3; i++) send_beat($urandom, 4'hF, i == 2, 1'b1);
    check("t2_len", o_len[0], 3);
    pulse_arm();

    for (int i = 0; i < 14; i++) send_beat($urandom, 4'hF, i == 13, 1'b0);
    check("t3_len", o_len[0], 11);
    check("t3_ovf", 32'(o_ovf[0]), 1);
    check("t3_one_len", o_len[2], 1);
    check("t3_one_ovf", 32'(o_ovf[2]), 1);
    pulse_arm();
    check("t3_ovf_clr", 32'(o_ovf[0]), 0);

    for (int i = 0; i < 13; i++) send_beat($urandom, 4'hF, i == 12, 1'b0);
    check("t4_wrap_len", o_len[1], 11);
    check("t4_wrap_ovf", 32'(o_ovf[1]), 1);
    pulse_arm();

    send_beat(32'h1111_1111, 4'hF, 1'b0, 1'b0);
    send_beat(32'h2222_2222, 4'h0, 1'b0, 1'b0);
    send_beat(32'h3333_3333, 4'h3, 1'b1, 1'b0);
    check("t5_we", o_we[0], 32'h3);
    check("t5_addr", o_addr[0], 1);
    check("t5_len", o_len[0], 2);
    pulse_arm();

    send_beat(32'h5555_0000, 4'hF, 1'b0, 1'b0);
    send_beat(32'h5555_0001, 4'hF, 1'b0, 1'b0);
    areset = 1'b1;
    #1;
    check("t6_en", 32'(o_en[0]), 0);
    check("t6_len", o_len[0], 0);
    check("t6_rdy", 32'(o_rdy[0]), 0);
    tick();
    tick();
    areset = 1'b0;
    tick();
    check("t6_rdy_up", 32'(o_rdy[0]), 1);
    for (int i = 0; i < 3; i++) send_beat(32'h6600_0000 + 32'(i), 4'hF, i == 2, 1'b0);
    check("t6_len_new", o_len[0], 3);
    check("t6_ovf_new", 32'(o_ovf[0]), 0);
    pulse_arm();

    for (int f = 0; f < 30; f++) begin
      flen = $urandom_range(1, 16);
      for (int unsigned b = 0; b < flen; b++) begin
        if ($urandom % 8 == 0) pulse_arm();
        k = ($urandom % 5 == 0) ? 4'h0 : 4'($urandom_range(1, 15));
        send_beat($urandom, k, b == flen - 1, ($urandom % 3) == 0);
      end
      check("rnd_done", 32'(o_done[0]), 1);
      junk = $urandom_range(0, 3);
      tvalid = 1'b1; tdata = $urandom; tkeep = 4'hF;
      repeat (junk) tick();
      tvalid = 1'b0;
      repeat ($urandom_range(0, 2)) tick();
      pulse_arm();
    end

    repeat (3) tick();
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
